// File: rtl/eth_rx_framer.sv
// Ethernet receive framer: strips preamble/SFD, checks CRC-32, strips FCS and
// flags runt, oversize and PHY-error frames on a byte stream with no backpressure.
module eth_rx_framer #(
  parameter int PRE_MIN   = 2,
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_er,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  output logic       m_err,
  output logic       stat_crc_err,
  output logic       stat_runt,
  output logic       stat_drop
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam int PW = $clog2(PRE_MIN + 1) + 1;
  localparam logic [PW-1:0] PRE_MIN_W = PW'(PRE_MIN);
  localparam logic [10:0]   MIN_W     = 11'(MIN_FRAME);
  localparam logic [10:0]   MAX_W     = 11'(MAX_FRAME);
  localparam logic [10:0]   LINE_LEN  = 11'd5;
  localparam logic [31:0]   CRC_RES   = 32'hDEBB20E3;

  logic [1:0]    state;
  logic [PW-1:0] pre_cnt;
  logic [10:0]   cnt;
  logic [31:0]   crc;
  logic [31:0]   crc_nxt;
  logic          err;
  logic [7:0]    line [5];
  logic          crc_bad;
  logic          runt;
  logic          line_full;

  always_comb begin
    crc_nxt = crc ^ {24'd0, s_data};
    for (int unsigned i = 0; i < 8; i++) begin
      crc_nxt = crc_nxt[0] ? ((crc_nxt >> 1) ^ 32'hEDB88320) : (crc_nxt >> 1);
    end
  end

  assign crc_bad   = (crc != CRC_RES);
  assign runt      = (cnt < MIN_W);
  assign line_full = (cnt >= LINE_LEN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      pre_cnt      <= '0;
      cnt          <= '0;
      crc          <= '1;
      err          <= 1'b0;
      m_data       <= '0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      m_err        <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_runt    <= 1'b0;
      stat_drop    <= 1'b0;
      for (int unsigned i = 0; i < 5; i++) line[i] <= '0;
    end else begin
      m_data       <= '0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      m_err        <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_runt    <= 1'b0;
      stat_drop    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (s_valid) begin
            if (s_data == 8'h55) begin
              state   <= S_PRE;
              pre_cnt <= PW'(1);
            end else begin
              state     <= S_DROP;
              stat_drop <= 1'b1;
            end
          end
        end
        S_PRE: begin
          if (!s_valid) begin
            state     <= S_IDLE;
            stat_drop <= 1'b1;
          end else if (s_data == 8'h55) begin
            if (pre_cnt != '1) pre_cnt <= pre_cnt + 1'b1;
          end else if (s_data == 8'hD5 && pre_cnt >= PRE_MIN_W) begin
            state <= S_DATA;
            crc   <= '1;
            cnt   <= '0;
            err   <= 1'b0;
          end else begin
            state     <= S_DROP;
            stat_drop <= 1'b1;
          end
        end
        S_DATA: begin
          if (s_valid) begin
            crc <= crc_nxt;
            if (cnt != '1) cnt <= cnt + 1'b1;
            line[0] <= s_data;
            for (int unsigned i = 1; i < 5; i++) line[i] <= line[i-1];
            if (s_er) err <= 1'b1;
            // Oversize: this beat pushes the count past MAX_FRAME, so close the frame early.
            if (cnt == MAX_W) begin
              m_valid <= 1'b1;
              m_data  <= line[4];
              m_last  <= 1'b1;
              m_err   <= 1'b1;
              cnt     <= '0;
              state   <= S_DROP;
            end else if (line_full) begin
              m_valid <= 1'b1;
              m_data  <= line[4];
            end
          end else begin
            // The four youngest entries are the FCS and are simply abandoned.
            if (line_full) begin
              m_valid      <= 1'b1;
              m_data       <= line[4];
              m_last       <= 1'b1;
              m_err        <= crc_bad | runt | err;
              stat_crc_err <= crc_bad;
              stat_runt    <= runt;
            end else begin
              stat_drop <= 1'b1;
            end
            cnt   <= '0;
            state <= S_IDLE;
          end
        end
        default: begin
          if (!s_valid) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Directed bench for eth_rx_framer: frames built with a bench-side CRC-32,
// output beats and status pulses collected by a monitor and compared per test.
module tb_eth_rx_framer;

  logic       clk;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_er;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_err;
  logic       stat_crc_err;
  logic       stat_runt;
  logic       stat_drop;

  eth_rx_framer #(.PRE_MIN(2), .MIN_FRAME(64), .MAX_FRAME(1518)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_er(s_er),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_err(m_err),
    .stat_crc_err(stat_crc_err), .stat_runt(stat_runt), .stat_drop(stat_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  logic [7:0] outq[$];
  int nv = 0, nl = 0, nc = 0, nr = 0, nd = 0, nbad = 0, last_pos = 0;
  logic last_err = 1'b0;

  always @(negedge clk) begin
    if (m_valid) begin
      outq.push_back(m_data);
      nv++;
      if (m_last) begin
        nl++;
        last_pos = nv;
        last_err = m_err;
      end
    end
    if (m_last && !m_valid) nbad++;
    if (stat_crc_err) nc++;
    if (stat_runt) nr++;
    if (stat_drop) nd++;
  end

  logic [7:0] pl[$];
  int cur_flip = -1;
  int b_nv, b_nl, b_nc, b_nr, b_nd, b_q, b_bad;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_payload(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back((i < 6) ? 8'hFF : 8'(i - 6));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = b;
    s_er    = e;
  endtask

  task automatic end_frame();
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_er    = 1'b0;
  endtask

  task automatic send_frame(input int npre, input int flip, input int er_idx, input bit with_fcs);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < pl.size(); i++) c = crc_byte(c, pl[i]);
    c = ~c;
    for (int i = 0; i < npre; i++) send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
    for (int i = 0; i < pl.size(); i++) begin
      b = pl[i] ^ ((i == flip) ? 8'h01 : 8'h00);
      send_byte(b, i == er_idx);
    end
    if (with_fcs) for (int i = 0; i < 4; i++) send_byte(c[8*i +: 8], 1'b0);
    end_frame();
  endtask

  task automatic snap();
    b_nv = nv; b_nl = nl; b_nc = nc; b_nr = nr; b_nd = nd; b_q = outq.size(); b_bad = nbad;
  endtask

  task automatic check_frames(input string tag, input int nframes, input int exp_n, input logic exp_err,
                              input int exp_crc, input int exp_runt, input int exp_drop);
    int mism;
    logic [7:0] e;
    mism = 0;
    for (int i = 0; i < nframes * exp_n; i++) begin
      e = pl[i % exp_n] ^ (((i % exp_n) == cur_flip) ? 8'h01 : 8'h00);
      if (b_q + i >= outq.size()) mism++;
      else if (outq[b_q + i] !== e) mism++;
    end
    check({tag, "_beats"}, nv - b_nv, nframes * exp_n);
    check({tag, "_data_mism"}, mism, 0);
    check({tag, "_lasts"}, nl - b_nl, (exp_n > 0) ? nframes : 0);
    if (exp_n > 0) begin
      check({tag, "_last_pos"}, last_pos - b_nv, nframes * exp_n);
      check({tag, "_m_err"}, {31'd0, last_err}, {31'd0, exp_err});
    end
    check({tag, "_crc_pulse"}, nc - b_nc, exp_crc);
    check({tag, "_runt_pulse"}, nr - b_nr, exp_runt);
    check({tag, "_drop_pulse"}, nd - b_nd, exp_drop);
    check({tag, "_orphan_last"}, nbad - b_bad, 0);
  endtask

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_er = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", {31'd0, m_valid}, 0);
    check("rst_m_last", {31'd0, m_last}, 0);
    check("rst_m_err", {31'd0, m_err}, 0);
    check("rst_m_data", {24'd0, m_data}, 0);
    check("rst_stats", {29'd0, stat_crc_err, stat_runt, stat_drop}, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Good 64-byte frame
    build_payload(60); cur_flip = -1;
    snap(); send_frame(7, -1, -1, 1); repeat (4) @(posedge clk);
    check_frames("good", 1, 60, 1'b0, 0, 0, 0);

    // Corrupted payload byte 10, FCS of the clean payload
    cur_flip = 10;
    snap(); send_frame(7, 10, -1, 1); repeat (4) @(posedge clk);
    check_frames("crc", 1, 60, 1'b1, 1, 0, 0);
    cur_flip = -1;

    // 44-byte runt with valid FCS
    build_payload(40);
    snap(); send_frame(7, -1, -1, 1); repeat (4) @(posedge clk);
    check_frames("runt", 1, 40, 1'b1, 0, 1, 0);

    // Short preamble dropped, then a good frame after one idle cycle
    build_payload(60);
    snap(); send_frame(1, -1, -1, 1); send_frame(7, -1, -1, 1); repeat (4) @(posedge clk);
    check_frames("shortpre", 1, 60, 1'b0, 0, 0, 1);

    // Two good frames back to back with one idle cycle
    snap(); send_frame(7, -1, -1, 1); send_frame(7, -1, -1, 1); repeat (4) @(posedge clk);
    check_frames("b2b", 2, 60, 1'b0, 0, 0, 0);

    // Only 3 bytes after SFD
    build_payload(3);
    snap(); send_frame(7, -1, -1, 0); repeat (4) @(posedge clk);
    check_frames("tiny", 1, 0, 1'b0, 0, 0, 1);

    // PHY error on byte 20 of a good 64-byte frame
    build_payload(60);
    snap(); send_frame(7, -1, 19, 1); repeat (4) @(posedge clk);
    check_frames("s_er", 1, 60, 1'b1, 0, 0, 0);

    // 1600-byte stream: cut at output byte 1514
    build_payload(1596);
    snap(); send_frame(7, -1, -1, 1); repeat (4) @(posedge clk);
    check_frames("oversize", 1, 1514, 1'b1, 0, 0, 0);

    // Asynchronous reset in the middle of a payload
    build_payload(60);
    for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) send_byte(pl[i], 1'b0);
    #2;
    check("pre_rst_valid", {31'd0, m_valid}, 1);
    rst = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, m_valid}, 0);
    check("async_rst_data", {24'd0, m_data}, 0);
    s_valid = 1'b0; s_data = 8'h00;
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    snap(); send_frame(7, -1, -1, 1); repeat (4) @(posedge clk);
    check_frames("post_rst", 1, 60, 1'b0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
